// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer:
// FSM states, access sizes, fault causes, byte-enable patterns and lane helpers.
package mem_seq_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    // Byte-enable pattern at offset 0; shifted right by the lane offset.
    localparam logic [3:0] BE_BYTE = 4'b1000;
    localparam logic [3:0] BE_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // True when the low address bits do not suit the access size.
    function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
        case (size)
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Lane offset actually used: offending low bits are dropped.
    function automatic logic [1:0] align_offset(input size_t size, input logic [1:0] off);
        case (size)
            SZ_HALF: align_offset = {off[1], 1'b0};
            SZ_WORD: align_offset = 2'b00;
            default: align_offset = off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated store data for
// the bus, plus lane selection and sign/zero extension of load data.
module mem_lane_align
    import mem_seq_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  size_t       size_i,
    input  logic        sign_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [1:0] off;
    assign off = align_offset(size_i, offset_i);

    // Lane enables, store replication and load extraction for the access size.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        be_o        = BE_WORD;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        byte_sel    = rdata_i[31:24];
        half_sel    = rdata_i[31:16];
        case (size_i)
            SZ_BYTE: begin
                be_o    = BE_BYTE >> off;
                wdata_o = {4{store_data_i[7:0]}};
                case (off)
                    2'd0:    byte_sel = rdata_i[31:24];
                    2'd1:    byte_sel = rdata_i[23:16];
                    2'd2:    byte_sel = rdata_i[15:8];
                    default: byte_sel = rdata_i[7:0];
                endcase
                load_data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o        = BE_HALF >> off;
                wdata_o     = {2{store_data_i[15:0]}};
                half_sel    = off[1] ? rdata_i[15:0] : rdata_i[31:16];
                load_data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            end
            default: begin
                be_o        = BE_WORD;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle data-memory access controller: stalls the core while a load or
// store runs on a handshaked bus, aborts on timeout, returns extended load data.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses fault instead of issuing.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_WR,
    input  logic        MEM_TO_REG,
    input  logic        MEM_BYTE_OP,
    input  logic        MEM_HALFWORD_OP,
    input  logic        MEM_SIGN_EXT,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        STALL,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q;
    size_t            size_q;
    logic             sign_q;
    logic [31:0]      sdata_q;
    logic             we_q;
    logic             load_q;
    logic             faulted_q;
    logic [1:0]       fault_cause_q;
    logic [31:0]      load_data_q;

    logic             request;
    size_t            size_in;
    logic             accept;
    logic             misalign;
    logic             capture;
    logic             timeout;
    logic             stall_c;
    logic             in_access;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_load;

    // Requests are not seen while reset is held, keeping STALL low in reset.
    assign request = (MEM_WR | MEM_TO_REG) & rst_n;
    assign size_in = MEM_BYTE_OP ? SZ_BYTE : (MEM_HALFWORD_OP ? SZ_HALF : SZ_WORD);

    mem_lane_align u_lane (
        .offset_i     (addr_q[1:0]),
        .size_i       (size_q),
        .sign_i       (sign_q),
        .store_data_i (sdata_q),
        .rdata_i      (bus_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load)
    );

    // Next-state, wait counter and handshake decisions for IDLE/ACCESS/DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        misalign  = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        stall_c   = 1'b0;
        in_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    stall_c = 1'b1;
                    accept  = 1'b1;
                    cnt_d   = '0;
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(size_in, addr[1:0])) begin
                        misalign = 1'b1;
                        state_d  = ST_DONE;
                    end else
`endif
                    begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                stall_c   = 1'b1;
                in_access = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (bus_ready) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched access fields, fault status and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            size_q        <= SZ_WORD;
            sign_q        <= 1'b0;
            sdata_q       <= '0;
            we_q          <= 1'b0;
            load_q        <= 1'b0;
            faulted_q     <= 1'b0;
            fault_cause_q <= FAULT_NONE;
            load_data_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q    <= addr;
                size_q    <= size_in;
                sign_q    <= MEM_SIGN_EXT;
                sdata_q   <= store_data;
                we_q      <= MEM_WR;
                load_q    <= MEM_TO_REG & ~MEM_WR;
                faulted_q <= misalign;
            end
            if (misalign) begin
                fault_cause_q <= FAULT_MISALIGN;
            end
            if (timeout) begin
                faulted_q     <= 1'b1;
                fault_cause_q <= FAULT_TIMEOUT;
            end
            if (capture) begin
                load_data_q <= lane_load;
            end
        end
    end

    assign STALL       = stall_c;
    assign bus_req     = in_access;
    assign bus_we      = we_q;
    assign bus_addr    = {addr_q[31:2], 2'b00};
    assign bus_be      = in_access ? lane_be : 4'b0000;
    assign bus_wdata   = lane_wdata;
    assign load_data   = load_data_q;
    assign load_valid  = (state_q == ST_DONE) & load_q & ~faulted_q;
    assign fault       = (state_q == ST_DONE) & faulted_q;
    assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: stimulus pushes expectations from a
// behavioural model, a monitor pops and compares on bus_req/load_valid/fault/STALL.
module tb_mem_access_sequencer;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_WR, MEM_TO_REG, MEM_BYTE_OP, MEM_HALFWORD_OP, MEM_SIGN_EXT;
    logic [31:0] addr, store_data;
    logic        STALL;
    logic [31:0] load_data;
    logic        load_valid, fault;
    logic [1:0]  fault_cause;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    mem_access_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_WR(MEM_WR), .MEM_TO_REG(MEM_TO_REG), .MEM_BYTE_OP(MEM_BYTE_OP),
        .MEM_HALFWORD_OP(MEM_HALFWORD_OP), .MEM_SIGN_EXT(MEM_SIGN_EXT),
        .addr(addr), .store_data(store_data),
        .STALL(STALL), .load_data(load_data), .load_valid(load_valid),
        .fault(fault), .fault_cause(fault_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] load_q[$];
    logic [1:0]  fault_q[$];
    int          stall_q[$];

    int          checks = 0;
    int          errors = 0;
    int          resp_delay = 0;
    logic [31:0] resp_rdata = '0;
    logic [1:0]  last_cause = 2'b00;
    int          txn_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: sz 0=word 1=half 2=byte; d = cycle index bus_ready rises.
    task automatic model(input bit st, input bit ld, input int sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int d);
        bus_exp_t    e;
        int          k;
        bit          mis;
        logic [31:0] v;
        mis = (sz == 1 && a[0]) || (sz == 0 && a[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            fault_q.push_back(2'b10);
            stall_q.push_back(1);
            last_cause = 2'b10;
            return;
        end
`endif
        k = int'(a[1:0]);
        if (sz == 1) k = k & 2;
        if (sz == 0) k = 0;
        e.addr = a & 32'hFFFF_FFFC;
        e.we   = st;
        if (sz == 2) begin
            e.be    = 4'(8 >> k);
            e.wdata = sd[7:0] * 32'h0101_0101;
        end else if (sz == 1) begin
            e.be    = 4'(12 >> k);
            e.wdata = sd[15:0] * 32'h0001_0001;
        end else begin
            e.be    = 4'hF;
            e.wdata = sd;
        end
        bus_q.push_back(e);
        if (d <= T - 1) begin
            stall_q.push_back(d + 2);
            if (ld && !st) begin
                if (sz == 2) begin
                    v = (rd >> ((3 - k) * 8)) & 32'hFF;
                    if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    v = (rd >> ((2 - k) * 8)) & 32'hFFFF;
                    if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end else begin
                    v = rd;
                end
                load_q.push_back(v);
            end
        end else begin
            stall_q.push_back(T + 1);
            fault_q.push_back(2'b01);
            last_cause = 2'b01;
        end
        if (mis) mis = 1'b0;
    endtask

    task automatic drive_idle();
        MEM_WR = 0; MEM_TO_REG = 0; MEM_BYTE_OP = 0; MEM_HALFWORD_OP = 0;
        MEM_SIGN_EXT = 0; addr = '0; store_data = '0;
    endtask

    // Issue one instruction from an IDLE cycle (posedge+1) and hold it through DONE.
    task automatic do_txn(input bit st, input bit ld, input int sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int d);
        int n;
        model(st, ld, sz, sx, a, sd, rd, d);
        resp_delay = d; resp_rdata = rd;
        MEM_WR = st; MEM_TO_REG = ld; MEM_BYTE_OP = (sz == 2);
        MEM_HALFWORD_OP = (sz == 1); MEM_SIGN_EXT = sx;
        addr = a; store_data = sd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (STALL && n < 50);
        if (n >= 50) begin
            errors++; checks++;
            $display("FAIL stall_bound: STALL still high after %0d cycles, expected release", n);
        end
        @(posedge clk); #1;
        drive_idle();
        txn_no++;
        $display("txn %0d: we=%0d ld=%0d sz=%0d sx=%0d addr=%h sd=%h rd=%h delay=%0d",
                 txn_no, st, ld, sz, sx, a, sd, rd, d);
    endtask

    // Memory responder: bus_ready after resp_delay ACCESS cycles, noise elsewhere.
    initial begin
        int wcnt;
        wcnt = 0;
        bus_ready = 0; bus_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus_req) begin
                bus_ready = (wcnt == resp_delay);
                bus_rdata = bus_ready ? resp_rdata : $urandom;
                wcnt++;
            end else begin
                wcnt = 0;
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expected responses when the DUT presents them.
    initial begin
        bus_exp_t cur;
        bit       prev_req;
        int       stall_cnt;
        prev_req = 0; stall_cnt = 0;
        cur = '{addr: '0, be: '0, we: 1'b0, wdata: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 0; stall_cnt = 0;
            end else begin
                if (bus_req && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected: bus_req=1 addr=%h, expected no request", bus_addr);
                    end else begin
                        cur = bus_q.pop_front();
                        chk("bus_addr", bus_addr, cur.addr);
                        chk("bus_be", 32'(bus_be), 32'(cur.be));
                        chk("bus_we", 32'(bus_we), 32'(cur.we));
                        chk("bus_wdata", bus_wdata, cur.wdata);
                    end
                end else if (bus_req) begin
                    chk("bus_stable", {bus_addr[31:2], bus_be[1:0]}, {cur.addr[31:2], cur.be[1:0]});
                end
                if (load_valid) begin
                    if (load_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL load_unexpected: load_valid=1 data=%h, expected none", load_data);
                    end else begin
                        chk("load_data", load_data, load_q.pop_front());
                    end
                end
                if (fault) begin
                    if (fault_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL fault_unexpected: fault=1 cause=%0d, expected none", fault_cause);
                    end else begin
                        chk("fault_cause", 32'(fault_cause), 32'(fault_q.pop_front()));
                    end
                end
                if (STALL) begin
                    stall_cnt++;
                end else if (stall_cnt > 0) begin
                    if (stall_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stall_unexpected: stall of %0d cycles, expected none", stall_cnt);
                    end else begin
                        chk("stall_len", 32'(stall_cnt), 32'(stall_q.pop_front()));
                    end
                    stall_cnt = 0;
                end
                prev_req = bus_req;
            end
        end
    end

    initial begin
        bus_exp_t e;
        rst_n = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(STALL), 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_load_valid", 32'(load_valid), 32'h0);
        chk("rst_fault", {30'h0, fault_cause} | 32'(fault), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        do_txn(1, 0, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_2222, 0);   // SW
        do_txn(0, 1, 2, 1, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);           // LB
        do_txn(0, 1, 2, 0, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);           // LBU
        do_txn(1, 0, 1, 0, 32'h0000_0202, 32'h0000_1234, 32'h0, 3);           // SH, ready late
        do_txn(0, 1, 0, 0, 32'h0000_0300, 32'h0, 32'hAAAA_5555, 9);           // timeout
        do_txn(0, 1, 0, 0, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1);           // misaligned LW
        do_txn(1, 1, 1, 1, 32'h0000_0410, 32'h0000_8765, 32'h0, 1);           // both: store
        do_txn(0, 1, 1, 1, 32'h0000_0412, 32'h0, 32'h1234_8001, 2);           // LH high bit

        // Reset mid-access: request drops asynchronously, no fault recorded.
        e.addr = 32'h0000_0500; e.be = 4'hF; e.we = 1'b0; e.wdata = 32'h0BAD_F00D;
        bus_q.push_back(e);
        resp_delay = 100;
        MEM_TO_REG = 1; addr = 32'h0000_0500; store_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #2;
        chk("pre_rst_req", 32'(bus_req), 32'h1);
        rst_n = 0;
        #1;
        chk("async_rst_req", 32'(bus_req), 32'h0);
        chk("async_rst_stall", 32'(STALL), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        last_cause = 2'b00;
        do_txn(0, 1, 2, 1, 32'h0000_0601, 32'h0, 32'h0080_0000, 1);

        for (int i = 0; i < 60; i++) begin
            bit          st, ld;
            int          sz;
            st = 1'($urandom_range(0, 1));
            ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = $urandom_range(0, 2);
            do_txn(st, ld, sz, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   $urandom_range(0, T + 1));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("fault_cause_hold", 32'(fault_cause), 32'(last_cause));
        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        chk("load_q_empty", 32'(load_q.size()), 32'h0);
        chk("fault_q_empty", 32'(fault_q.size()), 32'h0);
        chk("stall_q_empty", 32'(stall_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multi-cycle data-memory access controller between the decoder's memory control signals and a handshaked data-memory bus. On each load or store it drives the bus, stalls the core until the memory responds, then hands back size-extracted, sign- or zero-extended load data for writeback. It replaces the core's direct single-cycle memory port, so slow or variable-latency memory can sit behind the datapath.

## Interface
- TIMEOUT_CYCLES, 255: maximum bus wait cycles before an access is aborted; legal range 2..1023.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_WR  in  1  store request from the decoder.
- MEM_TO_REG  in  1  load request from the decoder.
- MEM_BYTE_OP  in  1  byte-sized access.
- MEM_HALFWORD_OP  in  1  halfword-sized access; word when neither size bit is set.
- MEM_SIGN_EXT  in  1  sign-extend load data; zero-extend when low.
- addr  in  32  effective byte address (ALU result).
- store_data  in  32  rt value; the low byte or halfword is used for sub-word stores.
- STALL  out  1  holds the PC and suppresses register writes while high.
- load_data  out  32  extended load result; valid only while load_valid is high.
- load_valid  out  1  one-cycle writeback strobe for loads.
- fault  out  1  one-cycle pulse when an access is aborted.
- fault_cause  out  2  01 timeout, 10 misaligned; held until the next fault.
- bus_req, bus_we  out  1  request and write enable.
- bus_addr  out  32  word-aligned address (bits 1:0 forced to 0).
- bus_be  out  4  byte lanes; be[3] corresponds to wdata[31:24].
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data; valid in the cycle bus_ready is high.
- bus_ready  in  1  completes the current request.

## Operation
- FSM with three states: IDLE, ACCESS, DONE.
- IDLE, no request: no action; STALL stays low.
- IDLE, MEM_WR or MEM_TO_REG high:
  - STALL goes high combinationally in the same cycle.
  - addr, size, sign and store data are registered.
  - Next state is ACCESS.
- Both request inputs high: treated as a store; the load is ignored.
- ACCESS:
  - bus_req stays high; bus_addr, bus_be, bus_we and bus_wdata stay stable.
  - A wait counter starts at 0 and increments each cycle.
  - bus_ready high: bus_rdata is captured, next state is DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without bus_ready: bus_req drops, fault pulses, fault_cause=01, next state is DONE.
- DONE:
  - STALL is low, so the core advances the PC at the end of this cycle.
  - For a non-faulted load, load_valid=1 and load_data is driven.
  - Next state is always IDLE. This single cycle prevents re-issuing the same instruction.
- Byte lanes (big-endian), with offset = addr[1:0]:
  - Byte: be = 1000 >> offset; wdata = store byte replicated on all four lanes.
  - Halfword: offset 0 gives be=1100, offset 2 gives be=0011; wdata = halfword replicated on both halves.
  - Word: be=1111.
- Loads select the addressed lane(s) of bus_rdata, then sign- or zero-extend to 32 bits.
- bus_we = stored MEM_WR.

## Timing
- Reset values: state IDLE, counter 0; STALL, load_valid, fault, bus_req and bus_we all 0; fault_cause=00; all data and address outputs 0.
- Reset asserted mid-access: bus_req drops immediately (asynchronously) and the access is discarded with no fault.
- A request is issued on the first bus clock edge after it is detected.
- Latency: a request accepted with bus_ready already high in the first ACCESS cycle gives STALL high for 2 cycles. Each wait cycle adds 1.
- Maximum STALL duration is TIMEOUT_CYCLES+1 cycles.
- bus_ready is ignored outside ACCESS.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses (halfword with addr[0]=1, word with addr[1:0]≠0) are not issued.
  - The FSM goes IDLE→DONE directly: fault pulses, fault_cause=10, STALL is high for 1 cycle, load_valid stays 0.
- MISALIGN_TRAP_EN undefined:
  - The offending low address bits are treated as 0.
  - The access proceeds normally; fault_cause=10 never occurs.

## Structure
- Package mem_seq_pkg:
  - state enum;
  - fault-cause constants FAULT_NONE, FAULT_TIMEOUT, FAULT_MISALIGN;
  - byte-enable constants per size.
- Sub-module mem_lane_align: combinational be/wdata generation and load extract/extend.
- The FSM and counter stay in the top module.

## Test plan
- SW to 0x100 of 0xDEADBEEF, bus_ready high on the first ACCESS cycle:
  - bus_be=1111, bus_wdata=0xDEADBEEF, bus_addr=0x100.
  - STALL high 2 cycles; no load_valid.
- LB from 0x103, rdata=0x000000F0, MEM_SIGN_EXT=1:
  - bus_be=0001.
  - load_data=0xFFFFFFF0 with load_valid for 1 cycle.
  - Repeated as LBU: load_data=0x000000F0.
- SH 0x1234 to 0x202, bus_ready delayed 3 cycles:
  - bus_be=0011, wdata=0x12341234.
  - STALL high 5 cycles.
- Load with bus_ready never asserted, TIMEOUT_CYCLES=4:
  - fault pulse, fault_cause=01, STALL high 5 cycles, load_valid stays 0.
- LW at 0x101:
  - With MISALIGN_TRAP_EN: fault_cause=10, bus_req never asserted.
  - Without it: bus_addr=0x100, normal completion.
- rst_n pulsed low during ACCESS: bus_req and STALL drop immediately; after release, the next request is issued normally.
